// File: rtl/sw_cfg_sched_if.sv
// Configuration handoff bundle between the switch scheduler and the display
// pipeline: the scheduler offers CFG_DATA with CFG_REQ and the consumer
// answers with CFG_ACK.
interface sw_cfg_sched_if;
    logic       CFG_REQ;
    logic [7:0] CFG_DATA;
    logic       CFG_ACK;

    modport master (
        output CFG_REQ,
        output CFG_DATA,
        input  CFG_ACK
    );

    modport slave (
        input  CFG_REQ,
        input  CFG_DATA,
        output CFG_ACK
    );
endinterface

// File: rtl/sw_cfg_sched.sv
// Switch-to-display configuration scheduler.
// Debounces the synchronized switch vector with one shared counter and
// flags each accepted change as pending. The pending update is released
// only at the start of vertical blanking, so mode/colour changes never tear
// mid-frame. It is offered to the display pipeline over a REQ/ACK handshake.
// Several changes within one frame coalesce into a single update carrying
// the latest value.
module sw_cfg_sched #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                  CLK,
    input  logic                  aclr_i,
    input  logic [7:0]            SYNC,
    input  logic                  VBLANK,
    sw_cfg_sched_if.master        cfg,
    output logic [7:0]            STABLE,
    output logic                  CHANGED,
    output logic                  BUSY
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        REQ     = 2'd2
    } state_t;

    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             vb_d;
    logic             vb_rise;
    logic             accept;
    logic             capture;
    logic [7:0]       cfg_data_q;
    state_t           state;
    state_t           state_nxt;

    // A candidate is accepted once it has been held for the full debounce
    // window and actually differs from the current debounced value; a value
    // that drifts back to STABLE before acceptance is silently dropped here.
    assign accept  = (SYNC == cand) && (cnt == CNT_MAX) && (cand != STABLE);
    assign vb_rise = VBLANK & ~vb_d;

    // Shared debounce counter: any difference in any bit restarts the window.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            cand    <= '0;
            cnt     <= '0;
            STABLE  <= '0;
            CHANGED <= 1'b0;
        end else begin
            CHANGED <= 1'b0;
            if (SYNC != cand) begin
                cand <= SYNC;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else if (accept) begin
                STABLE  <= cand;
                CHANGED <= 1'b1;
            end
        end
    end

    // Pending update flag; a new acceptance in the capture cycle wins so the
    // newer value is still delivered on the following frame.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end else if (capture) begin
            pending <= 1'b0;
        end
    end

    // Delayed VBLANK for rising-edge detection of the blanking interval.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            vb_d <= 1'b0;
        end else begin
            vb_d <= VBLANK;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: wait for a pending update, release it on the next
    // blanking rise, then hold the offer until the consumer acknowledges.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    state_nxt = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vb_rise) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (cfg.CFG_ACK) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold register for the offered word; it keeps the last delivered value
    // after the handshake completes.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            cfg_data_q <= '0;
        end else if (capture) begin
            cfg_data_q <= STABLE;
        end
    end

    assign cfg.CFG_REQ  = (state == REQ);
    assign cfg.CFG_DATA = cfg_data_q;
    assign BUSY         = (state != IDLE) | pending;

endmodule

// File: tb/tb_sw_cfg_sched.sv
// Directed bench for sw_cfg_sched with a short debounce window.
module tb_sw_cfg_sched;

    logic       CLK;
    logic       aclr_i;
    logic [7:0] SYNC;
    logic       VBLANK;
    logic [7:0] STABLE;
    logic       CHANGED;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    sw_cfg_sched_if cfg_if ();

    sw_cfg_sched #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (18)
    ) dut (
        .CLK     (CLK),
        .aclr_i  (aclr_i),
        .SYNC    (SYNC),
        .VBLANK  (VBLANK),
        .cfg     (cfg_if),
        .STABLE  (STABLE),
        .CHANGED (CHANGED),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        aclr_i         = 1'b1;
        SYNC           = 8'h00;
        VBLANK         = 1'b0;
        cfg_if.CFG_ACK = 1'b0;
        #3;
        aclr_i = 1'b0;
        tick();
    endtask

    // Hold SYNC at v long enough for it to be accepted (5 edges).
    task automatic debounce_to(input logic [7:0] v);
        SYNC = v;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        aclr_i         = 1'b1;
        SYNC           = 8'h00;
        VBLANK         = 1'b0;
        cfg_if.CFG_ACK = 1'b0;
        #7;
        checks++;
        if ({cfg_if.CFG_REQ, cfg_if.CFG_DATA, STABLE, CHANGED, BUSY} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b data=%h stable=%h chg=%b busy=%b want all 0",
                     cfg_if.CFG_REQ, cfg_if.CFG_DATA, STABLE, CHANGED, BUSY);
        end
        aclr_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cfg_if.CFG_REQ, STABLE, BUSY} !== 10'd0) begin
            errors++;
            $display("FAIL reset_idle got req=%b stable=%h busy=%b want 0",
                     cfg_if.CFG_REQ, STABLE, BUSY);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        SYNC = 8'hA5;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (STABLE !== 8'h00 || CHANGED !== 1'b0) begin
                errors++;
                $display("FAIL basic_early edge %0d stable=%h chg=%b want 00/0", i, STABLE, CHANGED);
            end
        end
        tick();
        checks++;
        if (STABLE !== 8'hA5 || CHANGED !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept stable=%h chg=%b want a5/1", STABLE, CHANGED);
        end
        tick();
        checks++;
        if (CHANGED !== 1'b0 || BUSY !== 1'b1 || cfg_if.CFG_REQ !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait chg=%b busy=%b req=%b want 0/1/0", CHANGED, BUSY, cfg_if.CFG_REQ);
        end
        VBLANK = 1'b1;
        tick();
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'hA5) begin
            errors++;
            $display("FAIL basic_req req=%b data=%h want 1/a5", cfg_if.CFG_REQ, cfg_if.CFG_DATA);
        end
        VBLANK         = 1'b0;
        cfg_if.CFG_ACK = 1'b1;
        tick();
        cfg_if.CFG_ACK = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b0 || BUSY !== 1'b0 || cfg_if.CFG_DATA !== 8'hA5) begin
            errors++;
            $display("FAIL basic_ack req=%b busy=%b data=%h want 0/0/a5",
                     cfg_if.CFG_REQ, BUSY, cfg_if.CFG_DATA);
        end
    endtask

    task automatic test_glitch();
        int chg_seen;
        int req_seen;
        chg_seen = 0;
        req_seen = 0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            SYNC = 8'h01;
            repeat (3) begin
                tick();
                if (CHANGED) chg_seen++;
                if (cfg_if.CFG_REQ) req_seen++;
            end
            SYNC = 8'h00;
            repeat (3) begin
                tick();
                if (CHANGED) chg_seen++;
                if (cfg_if.CFG_REQ) req_seen++;
            end
        end
        for (int f = 0; f < 3; f++) begin
            VBLANK = 1'b1;
            repeat (3) begin
                tick();
                if (cfg_if.CFG_REQ) req_seen++;
            end
            VBLANK = 1'b0;
            repeat (3) begin
                tick();
                if (cfg_if.CFG_REQ) req_seen++;
            end
        end
        checks++;
        if (chg_seen !== 0 || STABLE !== 8'h00) begin
            errors++;
            $display("FAIL glitch_stable changes=%0d stable=%h want 0/00", chg_seen, STABLE);
        end
        checks++;
        if (req_seen !== 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL glitch_req req_cycles=%0d busy=%b want 0/0", req_seen, BUSY);
        end
    endtask

    task automatic test_coalesce();
        int req_seen;
        req_seen = 0;
        apply_reset();
        debounce_to(8'h11);
        debounce_to(8'h22);
        checks++;
        if (STABLE !== 8'h22 || cfg_if.CFG_REQ !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL coalesce_pre stable=%h req=%b busy=%b want 22/0/1",
                     STABLE, cfg_if.CFG_REQ, BUSY);
        end
        VBLANK = 1'b1;
        tick();
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h22) begin
            errors++;
            $display("FAIL coalesce_req req=%b data=%h want 1/22", cfg_if.CFG_REQ, cfg_if.CFG_DATA);
        end
        VBLANK         = 1'b0;
        cfg_if.CFG_ACK = 1'b1;
        tick();
        cfg_if.CFG_ACK = 1'b0;
        repeat (2) tick();
        VBLANK = 1'b1;
        repeat (2) begin
            tick();
            if (cfg_if.CFG_REQ) req_seen++;
        end
        VBLANK = 1'b0;
        tick();
        checks++;
        if (req_seen !== 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_single extra_req=%0d busy=%b want 0/0", req_seen, BUSY);
        end
    endtask

    task automatic test_change_during_req();
        apply_reset();
        debounce_to(8'h11);
        tick();
        VBLANK = 1'b1;
        tick();
        VBLANK = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h11) begin
            errors++;
            $display("FAIL dreq_first req=%b data=%h want 1/11", cfg_if.CFG_REQ, cfg_if.CFG_DATA);
        end
        debounce_to(8'h33);
        checks++;
        if (STABLE !== 8'h33 || cfg_if.CFG_DATA !== 8'h11) begin
            errors++;
            $display("FAIL dreq_stable stable=%h data=%h want 33/11", STABLE, cfg_if.CFG_DATA);
        end
        for (int f = 0; f < 3; f++) begin
            VBLANK = 1'b1;
            repeat (2) tick();
            VBLANK = 1'b0;
            repeat (2) tick();
            checks++;
            if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h11) begin
                errors++;
                $display("FAIL dreq_hold frame %0d req=%b data=%h want 1/11",
                         f, cfg_if.CFG_REQ, cfg_if.CFG_DATA);
            end
        end
        cfg_if.CFG_ACK = 1'b1;
        tick();
        cfg_if.CFG_ACK = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL dreq_ack req=%b busy=%b want 0/1", cfg_if.CFG_REQ, BUSY);
        end
        tick();
        VBLANK = 1'b1;
        tick();
        VBLANK = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h33) begin
            errors++;
            $display("FAIL dreq_second req=%b data=%h want 1/33", cfg_if.CFG_REQ, cfg_if.CFG_DATA);
        end
        cfg_if.CFG_ACK = 1'b1;
        tick();
        cfg_if.CFG_ACK = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || cfg_if.CFG_DATA !== 8'h33) begin
            errors++;
            $display("FAIL dreq_done busy=%b data=%h want 0/33", BUSY, cfg_if.CFG_DATA);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        debounce_to(8'h11);
        tick();
        SYNC = 8'h44;
        repeat (4) tick();
        VBLANK = 1'b1;
        tick();
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h11 ||
            STABLE !== 8'h44 || CHANGED !== 1'b1) begin
            errors++;
            $display("FAIL coinc_capture req=%b data=%h stable=%h chg=%b want 1/11/44/1",
                     cfg_if.CFG_REQ, cfg_if.CFG_DATA, STABLE, CHANGED);
        end
        cfg_if.CFG_ACK = 1'b1;
        tick();
        cfg_if.CFG_ACK = 1'b0;
        VBLANK         = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL coinc_pending req=%b busy=%b want 0/1", cfg_if.CFG_REQ, BUSY);
        end
        repeat (2) tick();
        VBLANK = 1'b1;
        tick();
        VBLANK = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h44) begin
            errors++;
            $display("FAIL coinc_next req=%b data=%h want 1/44", cfg_if.CFG_REQ, cfg_if.CFG_DATA);
        end
        cfg_if.CFG_ACK = 1'b1;
        tick();
        cfg_if.CFG_ACK = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        int req_seen;
        req_seen = 0;
        apply_reset();
        debounce_to(8'h55);
        tick();
        VBLANK = 1'b1;
        tick();
        VBLANK = 1'b0;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b1 || cfg_if.CFG_DATA !== 8'h55) begin
            errors++;
            $display("FAIL arst_pre req=%b data=%h want 1/55", cfg_if.CFG_REQ, cfg_if.CFG_DATA);
        end
        #2;
        aclr_i = 1'b1;
        SYNC   = 8'h00;
        #1;
        checks++;
        if (cfg_if.CFG_REQ !== 1'b0 || cfg_if.CFG_DATA !== 8'h00 ||
            STABLE !== 8'h00 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL arst_async req=%b data=%h stable=%h busy=%b want 0/00/00/0",
                     cfg_if.CFG_REQ, cfg_if.CFG_DATA, STABLE, BUSY);
        end
        #2;
        aclr_i = 1'b0;
        for (int f = 0; f < 3; f++) begin
            repeat (3) begin
                tick();
                if (cfg_if.CFG_REQ) req_seen++;
            end
            VBLANK = 1'b1;
            repeat (3) begin
                tick();
                if (cfg_if.CFG_REQ) req_seen++;
            end
            VBLANK = 1'b0;
        end
        checks++;
        if (req_seen !== 0 || BUSY !== 1'b0 || STABLE !== 8'h00) begin
            errors++;
            $display("FAIL arst_quiet req_cycles=%0d busy=%b stable=%h want 0/0/00",
                     req_seen, BUSY, STABLE);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_coalesce();
        test_change_during_req();
        test_back_to_back();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_cfg_sched.md
Name: sw_cfg_sched

Overview:
Controller between the 8-bit switch synchronizer and the VGA display pipeline. It debounces the synchronized switch vector and detects changes to it. It then schedules one configuration update per change, released only at the start of vertical blanking and handed off with a REQ/ACK handshake. This keeps mode/colour changes from tearing mid-frame.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles SYNC must hold unchanged before acceptance (10 ms at 25 MHz); legal range 2..2^CNT_W-1
CNT_W, 18, debounce counter width

Ports:
CLK  input  1  system/pixel clock
aclr_i  input  1  reset, asynchronous, active-high
SYNC  input  8  synchronized switch vector from the 2-stage synchronizer
VBLANK  input  1  vertical blanking flag from VGA timing, synchronous to CLK
CFG_ACK  input  1  display pipeline has consumed CFG_DATA
CFG_REQ  output  1  configuration update pending at consumer
CFG_DATA  output  8  configuration word offered to display pipeline
STABLE  output  8  current debounced switch vector
CHANGED  output  1  one-cycle pulse when STABLE takes a new value
BUSY  output  1  high when the FSM is not in IDLE or an update is pending

Behaviour:
- Clock and reset: reset aclr_i, asynchronous, active-high; clock CLK. All state is in flops on posedge CLK, cleared on posedge aclr_i.
- Reset values: cand=0, cnt=0, STABLE=0, CHANGED=0, pending=0, vb_d=0, state=IDLE, CFG_REQ=0, CFG_DATA=0, BUSY=0.
- Debounce uses one shared counter for the whole vector:
  - If SYNC != cand: cand<=SYNC and cnt<=0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - Else (cnt == DEBOUNCE_CYCLES-1, saturated): if cand != STABLE, STABLE<=cand, CHANGED pulses 1 cycle, and pending is set.
- Debounce latency: a new vector held constant appears on STABLE exactly DEBOUNCE_CYCLES cycles after cand is loaded (DEBOUNCE_CYCLES+1 cycles after the SYNC change).
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches STABLE.
- A value that returns to STABLE before acceptance produces no CHANGED and no update.
- vb_d<=VBLANK every cycle; vb_rise = VBLANK & ~vb_d.
- FSM states and transitions:
  - IDLE: if pending, go to WAIT_VB.
  - WAIT_VB: on vb_rise, CFG_DATA<=STABLE, clear pending, go to REQ. If VBLANK is already high on entry, wait for the next rising edge.
  - REQ: CFG_REQ=1 (registered; equals state==REQ). CFG_DATA is held constant. On CFG_ACK=1, go to IDLE and CFG_REQ drops the next cycle.
- CFG_ACK is ignored outside REQ.
- Pending is a set/clear flag; set wins. If STABLE updates in the same cycle as the WAIT_VB capture, CFG_DATA takes the old STABLE and pending stays 1. The new value goes out at the following frame.
- Changes arriving during REQ set pending; after ACK the FSM returns through IDLE to WAIT_VB. At most one update goes out per frame.
- Multiple changes before a vblank coalesce: only the latest STABLE is sent.
- CFG_DATA keeps its last delivered value after ACK (hold register for the consumer).
- BUSY = (state != IDLE) | pending.
- Reset asserted mid-handshake drops CFG_REQ immediately and discards the pending update.
- No transaction follows reset unless a debounced SYNC differs from 0.

Test Plan:
1. DEBOUNCE_CYCLES=4, SYNC 0x00->0xA5 held -> CHANGED pulse with STABLE=0xA5 at the 5th CLK after the change. On the next VBLANK rise, CFG_REQ=1 with CFG_DATA=0xA5. ACK -> CFG_REQ=0 the next cycle, BUSY=0.
2. SYNC toggles 0x00->0x01->0x00 with 3-cycle pulses -> STABLE stays 0x00, no CHANGED, CFG_REQ never asserts.
3. Debounced 0x11 then 0x22, both before the VBLANK rise -> exactly one transaction, CFG_DATA=0x22.
4. STABLE becomes 0x33 while in REQ (0x11 offered, ACK withheld 3 frames) -> CFG_DATA holds 0x11 until ACK. The next frame's VBLANK rise produces a second REQ with 0x33.
5. STABLE update coincides with the WAIT_VB vb_rise cycle -> CFG_DATA=old value, pending=1, and the new value is sent on the following frame.
6. aclr_i pulsed while CFG_REQ=1 -> CFG_REQ, CFG_DATA, STABLE read 0 asynchronously; with SYNC=0x00 there are no further transactions.
